// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes a MIPS instruction word and runs one ALU operation per
// valid/ready handshake; MULTU/DIVU iterate one bit per cycle (shift-add / restoring).
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [5:0]       alu_op,
    output logic [2:0]       flags
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           r_state, w_next;
    logic [5:0]       r_op, w_op;
    logic [2:0]       r_flags;
    logic [WIDTH-1:0] r_a, r_hi, r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             w_bad_opc, w_ill, w_ovf, w_dz, w_multi, w_ge, w_unused;
    logic [WIDTH-1:0] w_res, w_hi, w_sum, w_diff;
    logic [4:0]       w_shamt;
    logic [WIDTH:0]   w_madd, w_rsh, w_dsub;

    assign w_unused = ^instr[25:11];
    assign w_shamt  = instr[10:6] & 5'(WIDTH - 1);
    assign w_sum    = src_a + src_b;
    assign w_diff   = src_a - src_b;
    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_rsh    = {r_hi, r_lo[WIDTH-1]};
    assign w_dsub   = w_rsh - {1'b0, r_a};
    assign w_ge     = !w_dsub[WIDTH];

    always_comb begin
        w_op      = '0;
        w_bad_opc = 1'b0;
        case (instr[31:26])
            6'h00:               w_op = instr[5:0];
            6'h08, 6'h23, 6'h2b: w_op = 6'h20;
            6'h09:               w_op = 6'h21;
            6'h0a:               w_op = 6'h2a;
            6'h0b:               w_op = 6'h2b;
            6'h0c:               w_op = 6'h24;
            6'h0d:               w_op = 6'h25;
            6'h0e:               w_op = 6'h26;
            default:             w_bad_opc = 1'b1;
        endcase
    end

    // Single-cycle results are produced here and registered at accept time.
    always_comb begin
        w_res   = '0;
        w_hi    = '0;
        w_ill   = w_bad_opc;
        w_ovf   = 1'b0;
        w_dz    = 1'b0;
        w_multi = 1'b0;
        if (!w_bad_opc) begin
            case (w_op)
                6'h20: begin
                    w_res = w_sum;
                    w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
                end
                6'h21: w_res = w_sum;
                6'h22: begin
                    w_res = w_diff;
                    w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
                end
                6'h23: w_res = w_diff;
                6'h24: w_res = src_a & src_b;
                6'h25: w_res = src_a | src_b;
                6'h26: w_res = src_a ^ src_b;
                6'h27: w_res = ~(src_a | src_b);
                6'h2a: w_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                6'h2b: w_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
                6'h00: w_res = src_b << w_shamt;
                6'h02: w_res = src_b >> w_shamt;
                6'h03: w_res = $signed(src_b) >>> w_shamt;
                6'h19: begin
                    w_ill   = !ENABLE_MULDIV;
                    w_multi = ENABLE_MULDIV;
                end
                6'h1b: begin
                    w_ill   = !ENABLE_MULDIV;
                    w_dz    = ENABLE_MULDIV && (src_b == '0);
                    w_multi = ENABLE_MULDIV && (src_b != '0);
                    w_res   = w_dz ? '1 : '0;
                    w_hi    = w_dz ? src_a : '0;
                end
                default: w_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_multi ? CALC : DONE) : IDLE;
            CALC:    w_next = (r_cnt == CW'(WIDTH - 1)) ? DONE : CALC;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // In CALC, r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_flags <= '0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_op    <= w_op;
            r_flags <= {w_ill, w_dz, w_ovf};
            r_a     <= src_b;
            r_cnt   <= '0;
            r_div   <= w_op[1];
            r_hi    <= w_multi ? '0 : w_hi;
            r_lo    <= w_multi ? src_a : w_res;
        end else if (r_state == CALC) begin
            r_cnt   <= r_cnt + 1'b1;
            r_hi    <= r_div ? (w_ge ? w_dsub[WIDTH-1:0] : w_rsh[WIDTH-1:0]) : w_madd[WIDTH:1];
            r_lo    <= r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_lo;
    assign result_hi = r_hi;
    assign alu_op    = r_op;
    assign flags     = r_flags;
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (WIDTH >= 8, power of two).
REQ-002 SHALL have parameter ENABLE_MULDIV, default 1; when 0, MULTU/DIVU decode as illegal.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port instr  input  32  MIPS-format instruction word.
REQ-008 SHALL have port src_a  input  WIDTH  operand A.
REQ-009 SHALL have port src_b  input  WIDTH  operand B, immediate already extended by the datapath.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  primary result (LO for MULTU/DIVU).
REQ-013 SHALL have port result_hi  output  WIDTH  HI for MULTU/DIVU, 0 otherwise.
REQ-014 SHALL have port alu_op  output  6  registered decoded operation code.
REQ-015 SHALL have port flags  output  3  {illegal, div_by_zero, overflow}.

Function
REQ-016 SHALL decode: opcode 0x00 -> alu_op = instr[5:0]; 0x08->0x20, 0x09->0x21, 0x0a->0x2a, 0x0b->0x2b, 0x0c->0x24, 0x0d->0x25, 0x0e->0x26, 0x23->0x20, 0x2b->0x20; other opcodes -> 0x00 with illegal=1.
REQ-017 SHALL support alu_op: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2a SLT (signed), 0x2b SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x19 MULTU, 0x1b DIVU; any other R-type funct -> result 0, illegal=1.
REQ-018 SHALL shift src_b by instr[10:6] modulo WIDTH for SLL/SRL/SRA.
REQ-019 SHALL set overflow=1 only for ADD/SUB on signed overflow; result still the wrapped WIDTH-bit sum/difference.
REQ-020 SHALL implement FSM IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-021 SHALL accept on in_valid && in_ready at edge T, capturing instr, operands and alu_op.
REQ-022 SHALL, for single-cycle ops (all except MULTU/DIVU, including illegal), go IDLE->DONE; out_valid high from T+1.
REQ-023 SHALL, for MULTU/DIVU, go IDLE->CALC, run WIDTH iterations (shift-add multiply, restoring divide), then DONE; out_valid high from T+WIDTH+1.
REQ-024 SHALL, for DIVU with src_b==0, skip CALC: result all ones, result_hi = src_a, div_by_zero=1, out_valid from T+1.
REQ-025 SHALL hold result, result_hi, alu_op, flags stable while out_valid && !out_ready.
REQ-026 SHALL go DONE->IDLE on out_ready; in_ready rises the cycle after, no back-to-back accept in the same cycle.
REQ-027 SHALL ignore in_valid while not IDLE; operand changes during CALC do not affect the result.
REQ-028 SHALL compute MULTU as unsigned 2*WIDTH product {result_hi,result}; DIVU quotient in result, remainder in result_hi.

Reset
REQ-029 SHALL, on reset high at an edge, enter IDLE and clear result, result_hi, alu_op, flags, out_valid to 0; in_ready=1 the following cycle.
REQ-030 SHALL abort an in-flight CALC or DONE on reset; no out_valid pulse follows.

Verification
REQ-031 SHALL cover: opcode 0x00 funct 0x20, a=5, b=7 -> T+1 out_valid=1, result=12, alu_op=0x20, flags=0.
REQ-032 SHALL cover: opcode 0x0a, a=0xFFFFFFFF, b=1 -> result=1; opcode 0x0b same operands -> result=0; ADD a=0x7FFFFFFF b=1 -> result=0x80000000, overflow=1.
REQ-033 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> out_valid at T+33, result_hi=1, result=0xFFFFFFFE.
REQ-034 SHALL cover: DIVU 100/7 -> result=14, result_hi=2 at T+33; DIVU 0x55/0 -> T+1 result=0xFFFFFFFF, result_hi=0x55, div_by_zero=1.
REQ-035 SHALL cover: out_ready=0 for 3 cycles after ADD -> outputs constant, in_ready=0, new in_valid ignored.
REQ-036 SHALL cover: reset asserted at cycle T+10 of MULTU -> next cycle in_ready=1, out_valid=0, result=0; opcode 0x3f -> illegal=1, result=0.
